// File: rtl/calc_issue_ctrl.sv
// rtl/calc_issue_ctrl.sv - credit-based issue/collect controller for a fixed-latency arithmetic pipeline
// A tuple is issued only when a FIFO slot is reserved for its result, so results are never lost.
module calc_issue_ctrl #(
   parameter int WIDTH = 32,
   parameter int LAT   = 4,
   parameter int DEPTH = 8
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       s_valid,
   output logic                       s_ready,
   input  logic signed [WIDTH-1:0]    s_a,
   input  logic signed [WIDTH-1:0]    s_b,
   input  logic signed [WIDTH-1:0]    s_c,
   input  logic signed [WIDTH-1:0]    s_d,
   output logic                       pipe_vld,
   output logic signed [WIDTH-1:0]    pipe_a,
   output logic signed [WIDTH-1:0]    pipe_b,
   output logic signed [WIDTH-1:0]    pipe_c,
   output logic signed [WIDTH-1:0]    pipe_d,
   input  logic signed [WIDTH-1:0]    pipe_res,
   input  logic                       pipe_res_vld,
   output logic                       m_valid,
   input  logic                       m_ready,
   output logic signed [WIDTH-1:0]    m_data,
   output logic [$clog2(DEPTH):0]     occupancy,
   output logic [$clog2(DEPTH):0]     inflight,
   output logic                       err_overflow,
   output logic                       err_spurious
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || LAT < 1) begin : g_bad_param
      $error("calc_issue_ctrl: DEPTH must be a power of 2 >= 2 and LAT >= 1");
   end

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [CW-1:0]    occ_q;
   logic [CW-1:0]    infl_q;
   logic [CW:0]      credits_used;
   logic             issue;
   logic             pop;
   logic             full;
   logic             wr_en;
   logic             infl_zero;
   logic             infl_dec;

   // Credits come from registered counts only; a pop frees its credit next cycle.
   assign credits_used = {1'b0, occ_q} + {1'b0, infl_q};
   assign s_ready      = credits_used < (CW + 1)'(DEPTH);

   assign issue    = s_valid && s_ready;
   assign pipe_vld = issue;
   assign pipe_a   = s_a;
   assign pipe_b   = s_b;
   assign pipe_c   = s_c;
   assign pipe_d   = s_d;

   assign m_valid   = occ_q != '0;
   assign m_data    = mem[rd_ptr];
   assign pop       = m_valid && m_ready;
   assign full      = occ_q == CW'(DEPTH);
   assign wr_en     = pipe_res_vld && (!full || pop);
   assign infl_zero = infl_q == '0;
   assign infl_dec  = pipe_res_vld && !infl_zero;

   assign occupancy = occ_q;
   assign inflight  = infl_q;

   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_ptr] <= pipe_res;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr       <= '0;
         rd_ptr       <= '0;
         occ_q        <= '0;
         infl_q       <= '0;
         err_overflow <= 1'b0;
         err_spurious <= 1'b0;
      end else begin
         if (wr_en) wr_ptr <= wr_ptr + AW'(1);
         if (pop)   rd_ptr <= rd_ptr + AW'(1);

         case ({wr_en, pop})
            2'b10:   occ_q <= occ_q + CW'(1);
            2'b01:   occ_q <= occ_q - CW'(1);
            default: occ_q <= occ_q;
         endcase

         if (issue && !infl_dec)      infl_q <= infl_q + CW'(1);
         else if (!issue && infl_dec) infl_q <= infl_q - CW'(1);

         if (pipe_res_vld && full && !pop) err_overflow <= 1'b1;
         if (pipe_res_vld && infl_zero)    err_spurious <= 1'b1;
      end
   end
endmodule

// File: tb/tb_calc_issue_ctrl.sv
// tb/tb_calc_issue_ctrl.sv - scoreboard bench for calc_issue_ctrl with a behavioural pipeline model
module tb_calc_issue_ctrl;
   localparam int WIDTH = 32;
   localparam int LAT   = 4;
   localparam int DEPTH = 8;
   localparam int CW    = $clog2(DEPTH) + 1;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic                    s_valid = 1'b0;
   logic                    s_ready;
   logic signed [WIDTH-1:0] s_a = '0, s_b = '0, s_c = '0, s_d = '0;
   logic                    pipe_vld;
   logic signed [WIDTH-1:0] pipe_a, pipe_b, pipe_c, pipe_d;
   logic signed [WIDTH-1:0] pipe_res;
   logic                    pipe_res_vld;
   logic                    m_valid;
   logic                    m_ready = 1'b0;
   logic signed [WIDTH-1:0] m_data;
   logic [CW-1:0]           occupancy, inflight;
   logic                    err_overflow, err_spurious;

   logic                    inj_vld = 1'b0;
   logic signed [WIDTH-1:0] inj_res = '0;
   logic [LAT-1:0]          vld_sr;
   logic signed [WIDTH-1:0] res_sr [LAT];

   int compared   = 0;
   int mismatched = 0;
   logic signed [WIDTH-1:0] exp_q [$];

   calc_issue_ctrl #(.WIDTH(WIDTH), .LAT(LAT), .DEPTH(DEPTH)) dut (
      .clk(clk), .rst(rst),
      .s_valid(s_valid), .s_ready(s_ready),
      .s_a(s_a), .s_b(s_b), .s_c(s_c), .s_d(s_d),
      .pipe_vld(pipe_vld),
      .pipe_a(pipe_a), .pipe_b(pipe_b), .pipe_c(pipe_c), .pipe_d(pipe_d),
      .pipe_res(pipe_res), .pipe_res_vld(pipe_res_vld),
      .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
      .occupancy(occupancy), .inflight(inflight),
      .err_overflow(err_overflow), .err_spurious(err_spurious)
   );

   function automatic logic signed [WIDTH-1:0] calc_ref(input logic signed [WIDTH-1:0] a, b, c, d);
      logic signed [WIDTH-1:0] t;
      t = (a - b) * (3 * c + 1) - 4 * d;
      return t / 2;
   endfunction

   // Pipeline model: shares rst and clears its valids like the real pipeline.
   always @(posedge clk) begin
      if (rst) vld_sr <= '0;
      else     vld_sr <= {vld_sr[LAT-2:0], pipe_vld};
      res_sr[0] <= calc_ref(pipe_a, pipe_b, pipe_c, pipe_d);
      for (int i = 1; i < LAT; i++) res_sr[i] <= res_sr[i-1];
   end
   assign pipe_res_vld = vld_sr[LAT-1] | inj_vld;
   assign pipe_res     = inj_vld ? inj_res : res_sr[LAT-1];

   always @(negedge clk) begin
      if (!rst && m_valid && m_ready) begin
         compared++;
         if (exp_q.size() == 0) begin
            mismatched++;
            $display("FAIL m_data_unexpected: got %0d required no output", m_data);
         end else begin
            if (m_data !== exp_q[0]) begin
               mismatched++;
               $display("FAIL m_data: got %0d required %0d", m_data, exp_q[0]);
            end
            void'(exp_q.pop_front());
         end
      end
   end

   task automatic check(input string name, input logic signed [63:0] act, input logic signed [63:0] req);
      compared++;
      if (act !== req) begin
         mismatched++;
         $display("FAIL %s: got %0d required %0d", name, act, req);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic signed [WIDTH-1:0] a, b, c, d, e, input int max_wait, output bit ok);
      s_valid = 1'b1;
      s_a = a; s_b = b; s_c = c; s_d = d;
      ok = 1'b0;
      for (int i = 0; i < max_wait && !ok; i++) begin
         @(negedge clk);
         if (s_ready) ok = 1'b1;
         @(posedge clk);
         #1;
      end
      if (ok) exp_q.push_back(e);
      s_valid = 1'b0;
   endtask

   task automatic drain(input string name, input int max);
      for (int i = 0; i < max && exp_q.size() != 0; i++) tick();
      check(name, exp_q.size(), 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      bit ok;
      int cnt;
      logic signed [WIDTH-1:0] a, b, c, d;

      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check("rst_m_valid", m_valid, 0);
      check("rst_occupancy", occupancy, 0);
      check("rst_inflight", inflight, 0);
      check("rst_s_ready", s_ready, 1);
      check("rst_pipe_vld", pipe_vld, 0);
      check("rst_errs", {err_overflow, err_spurious}, 0);

      // Single tuple: result 19 appears exactly at issue+5.
      tick();
      m_ready = 1'b1;
      send(10, 4, 2, 1, 19, 4, ok);
      check("single_accept", ok, 1);
      @(negedge clk);
      check("single_inflight", inflight, 1);
      for (int k = 2; k <= 6; k++) begin
         @(negedge clk);
         check($sformatf("single_m_valid_t%0d", k), m_valid, (k == 5) ? 1 : 0);
      end
      check("single_inflight_end", inflight, 0);
      check("single_delivered", exp_q.size(), 0);

      // Back-to-back streaming of 20 tuples.
      tick();
      cnt = 0;
      for (int i = 0; i < 20; i++) begin
         a = i * 7 - 30; b = i; c = i - 5; d = 3;
         send(a, b, c, d, calc_ref(a, b, c, d), 1, ok);
         if (!ok) cnt++;
      end
      check("stream_stalls", cnt, 0);
      drain("stream_drain", 40);
      check("stream_errs", {err_overflow, err_spurious}, 0);

      // Consumer stall: exactly DEPTH tuples accepted.
      m_ready = 1'b0;
      cnt = 0;
      for (int i = 0; i < 12; i++) begin
         a = 100 + i; b = -i; c = 2; d = i;
         send(a, b, c, d, calc_ref(a, b, c, d), 1, ok);
         cnt += int'(ok);
      end
      check("stall_accepted", cnt, 8);
      check("stall_s_ready", s_ready, 0);
      repeat (LAT + 2) tick();
      check("stall_occupancy", occupancy, 8);
      check("stall_inflight", inflight, 0);
      m_ready = 1'b1;
      @(negedge clk);
      check("stall_s_ready_pop_cycle", s_ready, 0);
      @(negedge clk);
      check("stall_s_ready_after_pop", s_ready, 1);
      tick();
      drain("stall_drain", 20);

      // Full FIFO: pop and return in the same cycle, three refills to exercise wrap.
      for (int r = 0; r < 3; r++) begin
         m_ready = 1'b0;
         cnt = 0;
         for (int j = 0; j < 8; j++) begin
            a = r * 50 + j; b = 7; c = j - 3; d = r;
            send(a, b, c, d, calc_ref(a, b, c, d), 1, ok);
            cnt += int'(ok);
         end
         check($sformatf("refill%0d_accepted", r), cnt, 8);
         repeat (LAT + 2) tick();
         check($sformatf("refill%0d_full", r), occupancy, 8);
         m_ready = 1'b1;
         inj_vld = 1'b1;
         inj_res = 1000 + r;
         exp_q.push_back(1000 + r);
         tick();
         inj_vld = 1'b0;
         check($sformatf("refill%0d_occ_simul", r), occupancy, 8);
         check($sformatf("refill%0d_no_overflow", r), err_overflow, 0);
         drain($sformatf("refill%0d_drain", r), 30);
      end
      check("refill_spurious_flag", err_spurious, 1);

      // Negative results round toward zero.
      send(0, 3, 1, 1, -8, 4, ok);
      send(1, 2, 0, 0, 0, 4, ok);
      drain("neg_drain", 20);

      // Reset mid-stream with 3 inflight and 2 queued.
      m_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         a = i + 1; b = 0; c = 0; d = 0;
         send(a, b, c, d, calc_ref(a, b, c, d), 1, ok);
      end
      tick();
      check("pre_rst_occupancy", occupancy, 2);
      check("pre_rst_inflight", inflight, 3);
      check("pre_rst_spurious_sticky", err_spurious, 1);
      rst = 1'b1;
      exp_q.delete();
      tick();
      rst = 1'b0;
      check("mid_rst_m_valid", m_valid, 0);
      check("mid_rst_occupancy", occupancy, 0);
      check("mid_rst_inflight", inflight, 0);
      check("mid_rst_s_ready", s_ready, 1);
      check("mid_rst_errs", {err_overflow, err_spurious}, 0);

      // Spurious return: flag set, result still captured.
      tick();
      inj_vld = 1'b1;
      inj_res = -77;
      exp_q.push_back(-77);
      tick();
      inj_vld = 1'b0;
      check("spurious_flag", err_spurious, 1);
      check("spurious_inflight", inflight, 0);
      check("spurious_captured", occupancy, 1);
      repeat (3) tick();
      check("spurious_sticky", err_spurious, 1);
      m_ready = 1'b1;
      drain("spurious_drain", 10);
      check("final_overflow", err_overflow, 0);

      repeat (3) tick();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end
endmodule

// File: doc/calc_issue_ctrl.md
Name: calc_issue_ctrl

Overview:
Initiator and collector for the team's fixed-latency, valid-only arithmetic pipeline (args a/b/c/d in, res/res_vld out, no backpressure). Accepts argument tuples on a valid/ready slave stream and issues them to the pipeline. Captures returning results in an internal FIFO and presents them on a valid/ready master stream. Credit accounting guarantees a result is never lost while the downstream consumer stalls.

Parameters:
WIDTH, 32, signed data width of arguments and result
LAT, 4, pipeline latency in cycles from issue to result (informational; credits do not depend on it)
DEPTH, 8, result FIFO entries; power of 2, DEPTH >= 2

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
s_valid  in  1  argument tuple valid
s_ready  out  1  tuple accepted when s_valid && s_ready
s_a, s_b, s_c, s_d  in  WIDTH each  signed arguments
pipe_vld  out  1  issue strobe to pipeline
pipe_a, pipe_b, pipe_c, pipe_d  out  WIDTH each  arguments to pipeline
pipe_res  in  WIDTH  signed pipeline result
pipe_res_vld  in  1  pipeline result strobe
m_valid  out  1  result available
m_ready  in  1  consumer accepts
m_data  out  WIDTH  FIFO head result
occupancy  out  $clog2(DEPTH)+1  entries held in FIFO
inflight  out  $clog2(DEPTH)+1  issued, not yet returned
err_overflow  out  1  sticky: result arrived while FIFO full
err_spurious  out  1  sticky: result arrived with inflight==0

Behaviour:
- Reset: FIFO pointers, occupancy, inflight, err flags = 0; m_valid=0; pipe_vld=0. FIFO storage is not reset. m_data undefined while m_valid=0.
- s_ready = (inflight + occupancy) < DEPTH, computed from registered state only; no combinational path from s_valid or m_ready. A pop in the current cycle does not free a credit until the next cycle.
- Issue is combinational pass-through: pipe_vld = s_valid && s_ready; pipe_a..d = s_a..d.
- inflight: +1 on issue, -1 on pipe_res_vld (when inflight>0). Simultaneous issue and return leaves it unchanged.
- Capture: on pipe_res_vld, write pipe_res at the write pointer, and the write pointer advances.
- Full FIFO on pipe_res_vld: the result is dropped, err_overflow is set, and pointers are unchanged. This is unreachable under correct credit use.
- Return with inflight==0: err_spurious is set, the result is still written if not full, and inflight stays 0.
- Output is show-ahead: m_valid = occupancy != 0; m_data = mem[rd_ptr]. Pop on m_valid && m_ready.
- Simultaneous write and pop: occupancy unchanged. Works when full (pop frees the slot and the write is accepted) and when empty (no pop, write lands).
- Write-to-m_valid latency: 1 cycle; the result appears on m_data the cycle after pipe_res_vld.
- Issue-to-m_valid latency: LAT+1 cycles.
- Pointers are $clog2(DEPTH) bits and wrap modulo DEPTH. Occupancy is tracked by a separate counter.
- Ordering: results are delivered strictly in issue order; the pipeline preserves order.
- Reset mid-operation: all counts clear in the reset cycle. The pipeline shares rst and clears its own valids, so no post-reset returns are expected. Any that do arrive raise err_spurious.
- err flags clear only on rst.
- Throughput: 1 tuple/cycle sustained while m_ready=1 and DEPTH > LAT+1. With DEPTH <= LAT+1, throughput is credit-limited to DEPTH per LAT+1 cycles.

Test Plan:
- Bench pipeline model: res = ((a-b)*(3c+1) - 4d) >>> 1, with negative results rounded toward zero, delayed LAT cycles.
- Single tuple: a=10, b=4, c=2, d=1, m_ready=1 -> pipe_vld for 1 cycle; m_valid=1 for 1 cycle at issue+5 with m_data=19; inflight returns to 0.
- Back-to-back streaming: 20 tuples with s_valid=1 continuously, m_ready=1, DEPTH=8 -> s_ready never drops; 20 results in order; no err flags.
- Consumer stall: m_ready=0, offer 12 tuples -> exactly 8 accepted, then s_ready=0. After returns, occupancy=8 and inflight=0. Raise m_ready -> 8 results in order; s_ready reasserts the cycle after the first pop.
- Full plus simultaneous: with the FIFO full (m_ready=0), assert m_ready and inject a return in the same cycle -> occupancy stays 8; no err_overflow; wrap-around ordering is correct over 3 full refills.
- Negative result: a=0, b=3, c=1, d=1 -> m_data=-8. Then a=1, b=2, c=0, d=0 -> m_data=0 (-1>>>1 rounded toward zero).
- Errors and reset: force pipe_res_vld with inflight=0 -> err_spurious=1 and stays set. Assert rst mid-stream with 3 inflight and 2 queued -> the next cycle has m_valid=0, occupancy=0, inflight=0, s_ready=1, and err flags cleared.
